// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, idle-high line.
// Bytes are offered on uart_data_rx / uart_have_data_rx and held until acknowledged.
module uart_rx #(
    parameter int DIV_WIDTH   = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic [DIV_WIDTH-1:0] uart_divider,
    output logic [7:0]           uart_data_rx,
    output logic                 uart_have_data_rx,
    input  logic                 uart_data_rx_ack,
    output logic                 uart_framing_error,
    output logic                 uart_overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    localparam logic [DIV_WIDTH-1:0] ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync;
    logic                   rs;

    state_t                 state, state_n;
    logic [DIV_WIDTH-1:0]   cnt, cnt_n;
    logic [DIV_WIDTH-1:0]   div_l, div_n;
    logic [2:0]             idx, idx_n;
    logic [7:0]             sh, sh_n;
    logic [7:0]             data_n;
    logic                   have_n, fe_n, ovr_n;
    logic                   tick, byte_done;

    assign rs   = sync[SYNC_STAGES-1];
    assign tick = (cnt == '0);

    // Synchronise the asynchronous rx pin; idle-high so flops reset to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], rx};
        end
    end

    // State, bit timer, shift register and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= S_IDLE;
            cnt                <= '0;
            div_l              <= '0;
            idx                <= '0;
            sh                 <= '0;
            uart_data_rx       <= '0;
            uart_have_data_rx  <= 1'b0;
            uart_framing_error <= 1'b0;
            uart_overrun       <= 1'b0;
        end else begin
            state              <= state_n;
            cnt                <= cnt_n;
            div_l              <= div_n;
            idx                <= idx_n;
            sh                 <= sh_n;
            uart_data_rx       <= data_n;
            uart_have_data_rx  <= have_n;
            uart_framing_error <= fe_n;
            uart_overrun       <= ovr_n;
        end
    end

    // Frame sequencing plus the consumer handshake on the stop-sample cycle.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        div_n     = div_l;
        idx_n     = idx;
        sh_n      = sh;
        data_n    = uart_data_rx;
        have_n    = uart_have_data_rx;
        ovr_n     = uart_overrun;
        fe_n      = 1'b0;
        byte_done = 1'b0;

        if (state == S_START || state == S_DATA || state == S_STOP) begin
            cnt_n = tick ? (div_l - ONE) : (cnt - ONE);
        end

        case (state)
            S_IDLE: begin
                if (!rs) begin
                    div_n   = uart_divider;
                    cnt_n   = (uart_divider >> 1) - ONE;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    if (rs) begin
                        state_n = S_IDLE;
                    end else begin
                        state_n = S_DATA;
                        idx_n   = '0;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    sh_n[idx] = rs;
                    idx_n     = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_n = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (rs) begin
                        byte_done = 1'b1;
                        state_n   = S_IDLE;
                    end else begin
                        fe_n    = 1'b1;
                        state_n = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rs) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // A completing byte takes priority over a plain ack; an ack in the same
        // cycle frees the slot so the new byte replaces the old one.
        if (byte_done) begin
            if (!uart_have_data_rx || uart_data_rx_ack) begin
                data_n = sh;
                have_n = 1'b1;
            end else begin
                ovr_n = 1'b1;
            end
        end else if (uart_data_rx_ack) begin
            have_n = 1'b0;
            ovr_n  = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed scenarios plus randomized frames, checked
// every cycle against an event-scheduled model of the receiver's outputs.
module tb_uart_rx;

    localparam int DW = 12;
    localparam int S  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx  = 1'b1;
    logic [DW-1:0] uart_divider = 12'd434;
    logic [7:0]    uart_data_rx;
    logic          uart_have_data_rx;
    logic          uart_data_rx_ack = 1'b0;
    logic          uart_framing_error;
    logic          uart_overrun;

    uart_rx #(.DIV_WIDTH(DW), .SYNC_STAGES(S)) dut (
        .clk                (clk),
        .rst                (rst),
        .rx                 (rx),
        .uart_divider       (uart_divider),
        .uart_data_rx       (uart_data_rx),
        .uart_have_data_rx  (uart_have_data_rx),
        .uart_data_rx_ack   (uart_data_rx_ack),
        .uart_framing_error (uart_framing_error),
        .uart_overrun       (uart_overrun)
    );

    always #5 clk = ~clk;

    // Expected outcome of one frame, due at an absolute clock-edge number.
    typedef struct {
        longint     edge_no;
        bit         fe;
        logic [7:0] b;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] got[$];
    longint     cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         fe_count = 0;
    int         ack_mode = 0;
    bit         ack_req = 1'b0;

    logic [7:0] m_data = '0;
    bit         m_have = 1'b0;
    bit         m_ovr = 1'b0;
    bit         m_fe = 1'b0;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Plays one frame on the pin (nseg segments of d cycles) and, for a full
    // frame, schedules its outcome at start + S + 1 + d/2 + 9*d edges.
    task automatic send(input logic [7:0] b, input int d, input bit stop_ok, input int nseg);
        ev_t        e;
        logic [9:0] bits;
        bits = {stop_ok, b, 1'b0};
        if (nseg == 10) begin
            e.edge_no = cyc + longint'(S + 1 + d / 2 + 9 * d);
            e.fe      = !stop_ok;
            e.b       = b;
            evq.push_back(e);
        end
        for (int i = 0; i < nseg; i++) begin
            rx = bits[i];
            step(d);
        end
    endtask

    task automatic ack_pulse();
        ack_req = 1'b1;
        step(1);
        ack_req = 1'b0;
    endtask

    task automatic wait_have(input int limit, output int n);
        n = 0;
        while (uart_have_data_rx !== 1'b1 && n < limit) begin
            step(1);
            n++;
        end
    endtask

    task automatic cyc_loop();
        forever begin
            @(posedge clk);
            cyc <= cyc + 1;
        end
    endtask

    task automatic ack_loop();
        forever begin
            @(posedge clk);
            #2;
            case (ack_mode)
                0:       uart_data_rx_ack = ack_req;
                1:       uart_data_rx_ack = uart_have_data_rx && !uart_data_rx_ack;
                default: uart_data_rx_ack = ($urandom_range(0, 3) == 0);
            endcase
        end
    endtask

    // Applies due frame outcomes and the ack seen at each edge to the
    // consumer-visible state.
    task automatic model_loop();
        ev_t        e;
        bit         done;
        bit         bad;
        logic [7:0] nb;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_data = '0;
                m_have = 1'b0;
                m_ovr  = 1'b0;
                m_fe   = 1'b0;
                evq.delete();
            end else begin
                done = 1'b0;
                bad  = 1'b0;
                nb   = '0;
                while (evq.size() > 0 && evq[0].edge_no <= cyc + 1) begin
                    e = evq.pop_front();
                    if (e.edge_no == cyc + 1) begin
                        if (e.fe) begin
                            bad = 1'b1;
                        end else begin
                            done = 1'b1;
                            nb   = e.b;
                        end
                    end
                end
                m_fe = bad;
                if (done) begin
                    if (!m_have || uart_data_rx_ack) begin
                        m_data = nb;
                        m_have = 1'b1;
                    end else begin
                        m_ovr = 1'b1;
                    end
                end else if (uart_data_rx_ack) begin
                    m_have = 1'b0;
                    m_ovr  = 1'b0;
                end
            end
        end
    endtask

    task automatic compare_loop();
        bit prev_have;
        prev_have = 1'b0;
        forever begin
            @(negedge clk);
            if (uart_framing_error === 1'b1) fe_count++;
            if (uart_have_data_rx === 1'b1 && !prev_have) got.push_back(uart_data_rx);
            prev_have = (uart_have_data_rx === 1'b1);
            if (!rst) begin
                checks++;
                if (uart_data_rx !== m_data || uart_have_data_rx !== m_have ||
                    uart_overrun !== m_ovr || uart_framing_error !== m_fe) begin
                    failures++;
                    $display("FAIL model_cmp cyc=%0d got data=%h have=%b ovr=%b fe=%b expected data=%h have=%b ovr=%b fe=%b",
                             cyc, uart_data_rx, uart_have_data_rx, uart_overrun, uart_framing_error,
                             m_data, m_have, m_ovr, m_fe);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int         n;
        int         f0;
        int         d;
        int         r;
        int         g;
        longint     c0;
        longint     e_edge;
        logic [7:0] b;

        fork
            cyc_loop();
            ack_loop();
            model_loop();
            compare_loop();
        join_none

        // Reset state
        step(3);
        chk("reset_state", 64'({uart_data_rx, uart_have_data_rx, uart_framing_error, uart_overrun}), 64'h0);
        rst = 1'b0;
        step(2);

        // Reset mid-frame, then a clean frame
        uart_divider = 12'd434;
        send(8'h55, 434, 1'b1, 4);
        rx = 1'b0;
        step(200);
        rst = 1'b1;
        rx  = 1'b1;
        step(3);
        chk("midframe_reset_outputs", 64'({uart_data_rx, uart_have_data_rx, uart_framing_error, uart_overrun}), 64'h0);
        rst = 1'b0;
        step(5);
        send(8'hA3, 434, 1'b1, 10);
        wait_have(600, n);
        chk("after_reset_timeout", 64'(n < 600), 64'h1);
        chk("after_reset_data", 64'(uart_data_rx), 64'hA3);
        ack_pulse();

        // Basic byte with exact latency and hold-until-ack
        uart_divider = 12'd4;
        step(3);
        c0 = cyc;
        send(8'hA5, 4, 1'b1, 10);
        wait_have(100, n);
        chk("basic_timeout", 64'(n < 100), 64'h1);
        chk("basic_latency", 64'(cyc - c0), 64'(S + 2 + 36 + 1));
        chk("basic_data", 64'(uart_data_rx), 64'hA5);
        step(5);
        chk("basic_hold", 64'(uart_have_data_rx), 64'h1);
        ack_pulse();
        chk("basic_ack_clear", 64'(uart_have_data_rx), 64'h0);

        // False start glitch
        uart_divider = 12'd8;
        f0 = fe_count;
        rx = 1'b0;
        step(2);
        rx = 1'b1;
        step(40);
        chk("glitch_no_data", 64'(uart_have_data_rx), 64'h0);
        chk("glitch_no_fe", 64'(fe_count - f0), 64'h0);

        // Framing error followed by a held-low line
        uart_divider = 12'd4;
        f0 = fe_count;
        send(8'h3C, 4, 1'b0, 10);
        step(50);
        rx = 1'b1;
        step(10);
        chk("break_single_fe", 64'(fe_count - f0), 64'h1);
        chk("break_no_data", 64'(uart_have_data_rx), 64'h0);
        send(8'h81, 4, 1'b1, 10);
        wait_have(100, n);
        chk("after_break_data", 64'(uart_data_rx), 64'h81);
        ack_pulse();

        // Overrun, then simultaneous ack on the stop-sample cycle
        send(8'h11, 4, 1'b1, 10);
        send(8'h22, 4, 1'b1, 10);
        step(5);
        chk("overrun_data", 64'(uart_data_rx), 64'h11);
        chk("overrun_flags", 64'({uart_have_data_rx, uart_overrun}), 64'h3);
        ack_pulse();
        chk("overrun_cleared", 64'({uart_have_data_rx, uart_overrun}), 64'h0);
        send(8'h33, 4, 1'b1, 10);
        e_edge = cyc + longint'(S + 1 + 2 + 36);
        fork
            send(8'h44, 4, 1'b1, 10);
            begin
                while (cyc < e_edge - 1) step(1);
                ack_req = 1'b1;
                step(1);
                ack_req = 1'b0;
            end
        join
        step(3);
        chk("simul_ack_data", 64'(uart_data_rx), 64'h44);
        chk("simul_ack_flags", 64'({uart_have_data_rx, uart_overrun}), 64'h2);
        ack_pulse();

        // Back-to-back frames with a divider change mid-frame
        ack_mode = 1;
        uart_divider = 12'd434;
        step(3);
        got.delete();
        send(8'h00, 434, 1'b1, 10);
        fork
            send(8'hFF, 434, 1'b1, 10);
            begin
                step(2000);
                uart_divider = 12'd100;
            end
        join
        send(8'h5A, 100, 1'b1, 10);
        step(10);
        chk("b2b_count", 64'(got.size()), 64'h3);
        if (got.size() == 3) begin
            chk("b2b_byte0", 64'(got[0]), 64'h00);
            chk("b2b_byte1", 64'(got[1]), 64'hFF);
            chk("b2b_byte2", 64'(got[2]), 64'h5A);
        end

        // Randomized frames, gaps, glitches, bad stops and ack timing
        ack_mode = 2;
        for (int k = 0; k < 40; k++) begin
            d = int'($urandom_range(4, 16));
            uart_divider = DW'(d);
            b = 8'($urandom);
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                g = int'($urandom_range(1, d / 2));
                rx = 1'b0;
                step(g);
                rx = 1'b1;
                step(d + S + 4);
            end else if (r == 1) begin
                send(b, d, 1'b0, 10);
                step(int'($urandom_range(1, 20)));
                rx = 1'b1;
                step(d + S + 4);
            end else begin
                send(b, d, 1'b1, 10);
                g = int'($urandom_range(0, 2)) * d;
                if (g > 0) step(g);
            end
        end
        ack_mode = 0;
        step(60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
